// File: rtl/wb_uart.sv
// wb_uart: Wishbone B4 classic slave 8N1 UART with TX FIFO, one-byte RX holding register and level irq.
module wb_uart #(
  parameter int WB_DATA_WIDTH = 32,
  parameter int WB_ADDR_WIDTH = 32,
  parameter int WB_SEL_WIDTH = 4,
  parameter int TX_FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET = 16'd434
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [WB_ADDR_WIDTH-1:0] wb_addr_i,
  input  logic [WB_DATA_WIDTH-1:0] wb_data_i,
  input  logic                     wb_we_i,
  input  logic [WB_SEL_WIDTH-1:0]  wb_sel_i,
  input  logic                     wb_stb_i,
  input  logic                     wb_cyc_i,
  output logic                     wb_ack_o,
  output logic [WB_DATA_WIDTH-1:0] wb_data_o,
  output logic                     tx_o,
  input  logic                     rx_i,
  output logic                     irq_o
);
  localparam int AW = $clog2(TX_FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  logic req, wr, rd, push, pop, full, empty, tx_empty, rd_data, rd_status;
  logic [1:0] a, irq_en;
  logic [15:0] div, div_eff;
  logic [31:0] rdata;
  logic [AW:0] wp, rp;
  logic [7:0] mem [TX_FIFO_DEPTH];
  state_t ts, ts_n, rs, rs_n;
  logic [15:0] tcnt, tdiv, rcnt, rdiv;
  logic [2:0] tbit, rbit;
  logic [7:0] tsh, rsh, rx_byte;
  logic s1, s2, rx_d, fall, rx_done, frame_set, rx_valid, overrun, frame_err;
  logic unused;
  assign unused = ^{wb_addr_i[WB_ADDR_WIDTH-1:4], wb_addr_i[1:0], wb_data_i[WB_DATA_WIDTH-1:16], wb_sel_i[WB_SEL_WIDTH-1:2]};
  assign a = wb_addr_i[3:2];
  assign req = wb_stb_i & wb_cyc_i & ~wb_ack_o;
  assign wr = req & wb_we_i & wb_sel_i[0];
  assign rd = req & ~wb_we_i;
  assign rd_data = rd & (a == 2'd0);
  assign rd_status = rd & (a == 2'd1);
  assign div_eff = div < 16'd2 ? 16'd2 : div;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign tx_empty = empty & (ts == IDLE);
  assign pop = ~empty & ((ts == IDLE) | ((ts == STOP) & (tcnt == 16'd0)));
  // A pop in the same cycle frees the slot the push lands in, so a full FIFO still accepts it.
  assign push = wr & (a == 2'd0) & (~full | pop);
  assign rdata = a == 2'd0 ? {24'b0, rx_byte} :
                 a == 2'd1 ? {27'b0, frame_err, overrun, rx_valid, tx_empty, full} :
                 a == 2'd2 ? {16'b0, div} : {30'b0, irq_en};
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      wb_ack_o <= 1'b0;
      wb_data_o <= '0;
      div <= DIV_RESET;
      irq_en <= 2'b0;
      irq_o <= 1'b0;
    end else begin
      wb_ack_o <= req;
      wb_data_o <= rd ? rdata : '0;
      if (wr && a == 2'd2) div[7:0] <= wb_data_i[7:0];
      if (wr && a == 2'd2 && wb_sel_i[1]) div[15:8] <= wb_data_i[15:8];
      if (wr && a == 2'd3) irq_en <= wb_data_i[1:0];
      irq_o <= (irq_en[0] & rx_valid) | (irq_en[1] & tx_empty);
    end
  always_ff @(posedge clk_i)
    if (push) mem[wp[AW-1:0]] <= wb_data_i[7:0];
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + {{AW{1'b0}}, 1'b1};
      if (pop) rp <= rp + {{AW{1'b0}}, 1'b1};
    end
  always_comb
    ts_n = pop ? START : tcnt != 16'd0 ? ts : ts == START ? DATA :
           ts == DATA ? (tbit == 3'd7 ? STOP : DATA) : ts == STOP ? IDLE : ts;
  // The divisor is latched at frame start so a DIV write never stretches a frame in flight.
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      ts <= IDLE;
      tcnt <= '0;
      tdiv <= 16'd2;
      tbit <= '0;
      tsh <= '0;
    end else begin
      ts <= ts_n;
      if (pop) begin
        tsh <= mem[rp[AW-1:0]];
        tdiv <= div_eff;
        tcnt <= div_eff - 16'd1;
        tbit <= '0;
      end else if (ts != IDLE) begin
        tcnt <= tcnt == 16'd0 ? tdiv - 16'd1 : tcnt - 16'd1;
        if (tcnt == 16'd0 && ts == DATA) begin
          tsh <= tsh >> 1;
          tbit <= tbit + 3'd1;
        end
      end
    end
  assign tx_o = ts == START ? 1'b0 : ts == DATA ? tsh[0] : 1'b1;
  assign fall = rx_d & ~s2;
  assign rx_done = (rs == STOP) & (rcnt == 16'd0) & s2;
  assign frame_set = (rs == STOP) & (rcnt == 16'd0) & ~s2;
  always_comb
    rs_n = rs == IDLE ? (fall ? START : IDLE) : rcnt != 16'd0 ? rs :
           rs == START ? (s2 ? IDLE : DATA) : rs == DATA ? (rbit == 3'd7 ? STOP : DATA) : IDLE;
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      rx_d <= 1'b1;
      rs <= IDLE;
      rcnt <= '0;
      rdiv <= 16'd2;
      rbit <= '0;
      rsh <= '0;
    end else begin
      s1 <= rx_i;
      s2 <= s1;
      rx_d <= s2;
      rs <= rs_n;
      if (rs == IDLE && fall) begin
        rdiv <= div_eff;
        rcnt <= (div_eff >> 1) - 16'd1;
      end else if (rs != IDLE) begin
        rcnt <= rcnt == 16'd0 ? rdiv - 16'd1 : rcnt - 16'd1;
        if (rcnt == 16'd0 && rs == START) rbit <= '0;
        if (rcnt == 16'd0 && rs == DATA) begin
          rsh <= {s2, rsh[7:1]};
          rbit <= rbit + 3'd1;
        end
      end
    end
  // A DATA read coinciding with a completing byte returns the old byte and loads the new one.
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      rx_byte <= '0;
      rx_valid <= 1'b0;
      overrun <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (rx_done && (!rx_valid || rd_data)) rx_byte <= rsh;
      rx_valid <= (rx_done & (~rx_valid | rd_data)) ? 1'b1 : rd_data ? 1'b0 : rx_valid;
      overrun <= (rx_done & rx_valid & ~rd_data) ? 1'b1 : rd_status ? 1'b0 : overrun;
      frame_err <= frame_set ? 1'b1 : rd_status ? 1'b0 : frame_err;
    end
endmodule
